// File: rtl/qtcore_scan_ctrl.sv
// qtcore_scan_ctrl
//   Host-side sequencer for the qtcore_a1 scan chain and processor enable.
//   A SCAN command exchanges the whole chain a byte at a time: each load byte
//   is shifted in MSB first while the bit falling out of the chain is captured,
//   so the unloaded image comes back byte-aligned with the loaded one. A RUN
//   command enables the processor for a bounded number of clocks. Scan enable
//   and processor enable are decoded from disjoint states and never overlap.
//
// Ports
//   clk_in, rst_n_in              clock (rising edge), async active-low reset
//   cmd_valid_in/cmd_ready_out    command handshake, accepted only in IDLE
//   cmd_op_in                     00=SCAN, 01=RUN, 1x=reserved (no-op)
//   cmd_cycles_in                 RUN length in clocks
//   abort_in                      synchronous abort of the current command
//   din_valid_in/din_ready_out    load byte handshake, din_data_in bit 7 first
//   dout_valid_out/dout_ready_in  captured byte handshake, bit 7 captured first
//   scan_enable_out, scan_data_out, scan_data_in   chain interface
//   proc_en_out, halt_in          processor interface
//   busy_out, done_out            status; done_out pulses for one clock
//   run_count_out                 processor clocks executed by the last RUN
//
// Optional build macro
//   QTCORE_SCAN_CTRL_HALT_STOP_EN  when defined, halt_in ends a RUN early; the
//                                  halted clock is neither enabled nor counted.

module qtcore_scan_ctrl #(
  parameter int unsigned SCAN_CHAIN_SIZE = 184,
  parameter int unsigned CYCLE_W         = 16
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               cmd_valid_in,
  output logic               cmd_ready_out,
  input  logic [1:0]         cmd_op_in,
  input  logic [CYCLE_W-1:0] cmd_cycles_in,
  input  logic               abort_in,
  input  logic               din_valid_in,
  input  logic [7:0]         din_data_in,
  output logic               din_ready_out,
  output logic               dout_valid_out,
  output logic [7:0]         dout_data_out,
  input  logic               dout_ready_in,
  output logic               scan_enable_out,
  output logic               scan_data_out,
  input  logic               scan_data_in,
  output logic               proc_en_out,
  input  logic               halt_in,
  output logic               busy_out,
  output logic               done_out,
  output logic [CYCLE_W-1:0] run_count_out
);

  localparam int unsigned SCAN_BYTES = SCAN_CHAIN_SIZE / 8;
  localparam int unsigned BCW        = $clog2(SCAN_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DRAIN,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         sr_q, sr_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [CYCLE_W-1:0] cyc_q, cyc_d;
  logic [CYCLE_W-1:0] run_cnt_q, run_cnt_d;
  logic               dout_valid_q, dout_valid_d;
  logic [7:0]         dout_data_q, dout_data_d;
  logic               scan_en_q, scan_en_d;
  logic               proc_en_q, proc_en_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               cmd_ready_q, cmd_ready_d;

  logic               dout_take;
  logic               din_take;
  logic               halt_stop;
  logic [7:0]         sr_shift;

`ifdef QTCORE_SCAN_CTRL_HALT_STOP_EN
  assign halt_stop = halt_in;
`else
  logic unused_halt;
  assign unused_halt = halt_in;
  assign halt_stop   = 1'b0;
`endif

  assign dout_take = dout_valid_q & dout_ready_in;
  // A new byte may only start shifting once the previous capture has left,
  // so the buffer can never be overwritten at the end of SHIFT.
  assign din_ready_out = (state_q == S_LOAD) & (~dout_valid_q | dout_ready_in);
  assign din_take      = din_ready_out & din_valid_in;
  assign sr_shift      = {sr_q[6:0], scan_data_in};

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    cyc_d        = cyc_q;
    run_cnt_d    = run_cnt_q;
    dout_valid_d = dout_valid_q;
    dout_data_d  = dout_data_q;

    if (dout_take) begin
      dout_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_in) begin
          unique case (cmd_op_in)
            2'b00: begin
              state_d    = S_LOAD;
              byte_cnt_d = BCW'(SCAN_BYTES);
            end
            2'b01: begin
              state_d   = S_RUN;
              cyc_d     = cmd_cycles_in;
              run_cnt_d = '0;
            end
            default: state_d = S_DONE;
          endcase
        end
      end
      S_LOAD: begin
        if (din_take) begin
          sr_d      = din_data_in;
          bit_cnt_d = 4'd8;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_d      = sr_shift;
        bit_cnt_d = bit_cnt_q - 4'd1;
        if (bit_cnt_q == 4'd1) begin
          dout_data_d  = sr_shift;
          dout_valid_d = 1'b1;
          byte_cnt_d   = byte_cnt_q - BCW'(1);
          state_d      = (byte_cnt_q == BCW'(1)) ? S_DRAIN : S_LOAD;
        end
      end
      S_DRAIN: begin
        if (!dout_valid_q || dout_take) begin
          state_d = S_DONE;
        end
      end
      S_RUN: begin
        if (halt_stop || cyc_q == '0) begin
          state_d = S_DONE;
        end else begin
          cyc_d     = cyc_q - 1'b1;
          run_cnt_d = run_cnt_q + 1'b1;
          if (cyc_q == CYCLE_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides the state step but keeps this clock's enable effects
    // (the chain shift or counted processor cycle that is already underway).
    if (abort_in && state_q != S_IDLE && state_q != S_DONE) begin
      state_d      = S_DONE;
      dout_valid_d = 1'b0;
      bit_cnt_d    = '0;
      byte_cnt_d   = '0;
      cyc_d        = '0;
    end
  end

  // Output flags are registered from the next state so they change with it.
  always_comb begin
    scan_en_d   = (state_d == S_SHIFT);
    proc_en_d   = (state_d == S_RUN) && (cyc_d != '0);
    done_d      = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= S_IDLE;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      cyc_q        <= '0;
      run_cnt_q    <= '0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      scan_en_q    <= 1'b0;
      proc_en_q    <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      cyc_q        <= cyc_d;
      run_cnt_q    <= run_cnt_d;
      dout_valid_q <= dout_valid_d;
      dout_data_q  <= dout_data_d;
      scan_en_q    <= scan_en_d;
      proc_en_q    <= proc_en_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      cmd_ready_q  <= cmd_ready_d;
    end
  end

  assign cmd_ready_out   = cmd_ready_q;
  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign scan_enable_out = scan_en_q;
  assign scan_data_out   = scan_en_q & sr_q[7];
  assign proc_en_out     = proc_en_q & ~halt_stop;
  assign dout_valid_out  = dout_valid_q;
  assign dout_data_out   = dout_data_q;
  assign run_count_out   = run_cnt_q;

endmodule

// File: tb/tb_qtcore_scan_ctrl.sv
// tb_qtcore_scan_ctrl
//   Bench for qtcore_scan_ctrl: a behavioural scan chain, a dout scoreboard
//   filled when a SCAN is issued and drained as captured bytes are consumed,
//   plus RUN, reserved-op, halt, abort and mid-shift reset scenarios.

module tb_qtcore_scan_ctrl;

  localparam int unsigned SIZE = 184;
  localparam int unsigned NB   = SIZE / 8;
  localparam int unsigned CW   = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_cycles;
  logic          abort;
  logic          din_valid;
  logic [7:0]    din_data;
  logic          din_ready;
  logic          dout_valid;
  logic [7:0]    dout_data;
  logic          dout_ready;
  logic          scan_en;
  logic          scan_do;
  logic          scan_di;
  logic          proc_en;
  logic          halt;
  logic          busy;
  logic          done;
  logic [CW-1:0] run_count;

  qtcore_scan_ctrl #(
    .SCAN_CHAIN_SIZE(SIZE),
    .CYCLE_W        (CW)
  ) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .cmd_valid_in   (cmd_valid),
    .cmd_ready_out  (cmd_ready),
    .cmd_op_in      (cmd_op),
    .cmd_cycles_in  (cmd_cycles),
    .abort_in       (abort),
    .din_valid_in   (din_valid),
    .din_data_in    (din_data),
    .din_ready_out  (din_ready),
    .dout_valid_out (dout_valid),
    .dout_data_out  (dout_data),
    .dout_ready_in  (dout_ready),
    .scan_enable_out(scan_en),
    .scan_data_out  (scan_do),
    .scan_data_in   (scan_di),
    .proc_en_out    (proc_en),
    .halt_in        (halt),
    .busy_out       (busy),
    .done_out       (done),
    .run_count_out  (run_count)
  );

  always #5 clk = ~clk;

  // Chain model: MSB is the chain output, new bits enter at bit 0.
  logic [SIZE-1:0] chain;
  logic [SIZE-1:0] chain_init;
  logic            chain_load;

  always @(posedge clk) begin
    if (chain_load)   chain <= chain_init;
    else if (scan_en) chain <= {chain[SIZE-2:0], scan_do};
  end
  assign scan_di = chain[SIZE-1];

  int         tests;
  int         fails;
  int         scan_clks;
  int         pen_cnt;
  int         dones;
  int         both_en;
  int         shift_with_dout;
  int         stalled;
  int         consumed;
  logic [7:0] sb[$];
  bit         hold_chk;
  logic [7:0] hold_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (scan_en) scan_clks++;
      if (proc_en) pen_cnt++;
      if (done) dones++;
      if (scan_en && proc_en) both_en++;
      if (scan_en && dout_valid) shift_with_dout++;
      if (hold_chk) check("dout_hold", {23'd0, dout_valid, dout_data}, {23'd0, 1'b1, hold_data});
      hold_chk  = dout_valid && !dout_ready;
      hold_data = dout_data;
      if (dout_valid && !dout_ready) stalled++;
      if (dout_valid && dout_ready) begin
        consumed++;
        if (sb.size() == 0) check("sb_depth", sb.size(), 1);
        else check("dout_byte", {24'd0, dout_data}, {24'd0, sb.pop_front()});
      end
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [CW-1:0] cyc);
    int k;
    @(posedge clk); #1;
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_cycles = cyc;
    k = 0;
    do begin @(negedge clk); k++; end while (!cmd_ready && k < 100);
    if (!cmd_ready) check("cmd_ready", {31'd0, cmd_ready}, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // n counts negedges after the accepting edge until done_out is seen.
  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < limit);
    if (!done) check("done_seen", {31'd0, done}, 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    repeat (gap) begin @(posedge clk); #1; end
    din_valid = 1'b1;
    din_data  = b;
    k = 0;
    do begin @(negedge clk); k++; end while (!din_ready && k < 2000);
    if (!din_ready) check("din_ready", {31'd0, din_ready}, 1);
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic preload_chain();
    @(posedge clk); #1;
    for (int unsigned k = 0; k < NB; k++) chain_init[SIZE-1-8*k -: 8] = 8'hA0 + 8'(k);
    chain_load = 1'b1;
    @(posedge clk); #1;
    chain_load = 1'b0;
  endtask

  task automatic run_scan(input string tg, input bit stall, input bit gaps);
    int base_s, base_d, base_c, base_st, n, mism;
    preload_chain();
    base_s  = scan_clks;
    base_d  = dones;
    base_c  = consumed;
    base_st = stalled;
    for (int unsigned k = 0; k < NB; k++) sb.push_back(8'hA0 + 8'(k));
    issue(2'b00, '0);
    fork
      begin
        for (int unsigned k = 0; k < NB; k++)
          send_byte(8'(k), gaps ? int'($urandom_range(1, 4)) : 0);
      end
      begin
        if (stall) begin
          int w;
          w = 0;
          while (consumed - base_c < 3 && w < 2000) begin @(posedge clk); #1; w++; end
          dout_ready = 1'b0;
          repeat (20) @(posedge clk);
          #1;
          dout_ready = 1'b1;
        end
      end
    join
    wait_done(3000, n);
    @(posedge clk); #1;
    check({tg, "_shift_clks"}, scan_clks - base_s, SIZE);
    check({tg, "_done_cnt"}, dones - base_d, 1);
    check({tg, "_sb_left"}, sb.size(), 0);
    mism = 0;
    for (int unsigned k = 0; k < NB; k++)
      if (chain[SIZE-1-8*k -: 8] !== 8'(k)) mism++;
    check({tg, "_chain_img"}, mism, 0);
    if (stall) check({tg, "_stall_long"}, (stalled - base_st >= 5) ? 1 : 0, 1);
  endtask

  initial begin
    int n, b_p, b_s, b_d, w, exp_rc;
    tests = 0; fails = 0; scan_clks = 0; pen_cnt = 0; dones = 0; both_en = 0;
    shift_with_dout = 0; stalled = 0; consumed = 0; hold_chk = 1'b0; hold_data = '0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_cycles = '0; abort = 1'b0;
    din_valid = 1'b0; din_data = '0; dout_ready = 1'b1; halt = 1'b0;
    chain_load = 1'b0; chain_init = '0;
    fork
      monitor();
      begin
        #7;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 1);
        check("rst_outs", {26'd0, busy, done, scan_en, proc_en, dout_valid, din_ready}, 0);
        check("rst_run_count", {16'd0, run_count}, 0);
        #5 rst_n = 1'b1;

        run_scan("scan", 1'b0, 1'b0);
        run_scan("stall", 1'b1, 1'b0);
        check("stall_no_shift", shift_with_dout, 0);
        run_scan("gaps", 1'b0, 1'b1);

        // RUN 8
        b_p = pen_cnt;
        issue(2'b01, 16'd8);
        wait_done(100, n);
        check("run8_latency", n, 9);
        @(posedge clk); #1;
        check("run8_pen", pen_cnt - b_p, 8);
        check("run8_count", {16'd0, run_count}, 8);

        // RUN 0
        b_p = pen_cnt;
        issue(2'b01, 16'd0);
        wait_done(100, n);
        check("run0_latency", n, 2);
        @(posedge clk); #1;
        check("run0_pen", pen_cnt - b_p, 0);
        check("run0_count", {16'd0, run_count}, 0);

        // Reserved op
        b_p = pen_cnt;
        b_s = scan_clks;
        issue(2'b10, 16'd5);
        wait_done(100, n);
        check("rsvd_latency", n, 1);
        @(posedge clk); #1;
        check("rsvd_enables", (pen_cnt - b_p) + (scan_clks - b_s), 0);

        // RUN 100 with halt after five executed cycles
        b_p = pen_cnt;
        issue(2'b01, 16'd100);
        w = 0;
        while (pen_cnt - b_p < 5 && w < 500) begin @(posedge clk); #1; w++; end
        halt = 1'b1;
        wait_done(300, n);
        @(posedge clk); #1;
        halt = 1'b0;
`ifdef QTCORE_SCAN_CTRL_HALT_STOP_EN
        exp_rc = 5;
`else
        exp_rc = 100;
`endif
        check("halt_count", {16'd0, run_count}, exp_rc);
        check("halt_pen", pen_cnt - b_p, exp_rc);

        // Abort during the fourth shift of the first byte
        b_s = scan_clks;
        b_d = dones;
        issue(2'b00, '0);
        send_byte(8'h5A, 0);
        w = 0;
        while (scan_clks - b_s < 3 && w < 100) begin @(posedge clk); #1; w++; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_outs", {28'd0, scan_en, proc_en, dout_valid, done}, 1);
        @(negedge clk);
        check("abort_idle", {30'd0, busy, cmd_ready}, 1);
        check("abort_done_cnt", dones - b_d, 1);

        // Asynchronous reset in the middle of a shift
        b_s = scan_clks;
        issue(2'b00, '0);
        send_byte(8'hC3, 0);
        w = 0;
        while (scan_clks - b_s < 3 && w < 100) begin @(posedge clk); #1; w++; end
        #1 rst_n = 1'b0;
        #1;
        check("mrst_cmd_ready", {31'd0, cmd_ready}, 1);
        check("mrst_outs", {25'd0, busy, done, scan_en, scan_do, proc_en, dout_valid, din_ready}, 0);
        check("mrst_run_count", {16'd0, run_count}, 0);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        check("never_both_en", both_en, 0);
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
